// File: rtl/pio_pkg.sv
// Shared constants for the debounced PIO interrupt block: Avalon register map and edge-mode encodings.
package pio_pkg;

  localparam int unsigned AVS_ADDR_W = 2;
  localparam int unsigned AVS_DATA_W = 32;

  localparam logic [AVS_ADDR_W-1:0] REG_DATA = 2'd0;
  localparam logic [AVS_ADDR_W-1:0] REG_MASK = 2'd1;
  localparam logic [AVS_ADDR_W-1:0] REG_EDGE = 2'd2;
  localparam logic [AVS_ADDR_W-1:0] REG_RAW  = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: 2-flop synchroniser, stability counter, accepted level and its delayed copy.
module pio_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_sync,
  output logic o_stable,
  output logic o_rise_c,
  output logic o_fall_c
);

  localparam int unsigned   CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Counter runs only while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta     <= IDLE_LEVEL;
      r_sync     <= IDLE_LEVEL;
      r_stable   <= IDLE_LEVEL;
      r_stable_d <= IDLE_LEVEL;
      r_cnt      <= '0;
    end else begin
      r_meta     <= i_raw;
      r_sync     <= r_meta;
      r_stable_d <= r_stable;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sync   = r_sync;
  assign o_stable = r_stable;
  assign o_rise_c = r_stable & ~r_stable_d;
  assign o_fall_c = ~r_stable & r_stable_d;

endmodule

// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO input block: per-channel debounce, sticky edge capture with W1C, maskable level irq.
module pio_debounce_irq
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_MODE       = 2,
  parameter bit          IDLE_LEVEL      = 1'b1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [WIDTH-1:0]      pio_in,
  input  logic [AVS_ADDR_W-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [AVS_DATA_W-1:0] avs_writedata,
  output logic [AVS_DATA_W-1:0] avs_readdata,
  output logic                  irq
);

  logic [WIDTH-1:0]      w_sync;
  logic [WIDTH-1:0]      w_stable;
  logic [WIDTH-1:0]      w_rise;
  logic [WIDTH-1:0]      w_fall;
  logic [WIDTH-1:0]      w_edge;
  logic [WIDTH-1:0]      w_w1c;
  logic                  w_mask_we;
  logic [AVS_DATA_W-1:0] w_rdata;
  logic                  w_unused_wdata;

  logic [WIDTH-1:0]      r_mask;
  logic [WIDTH-1:0]      r_edge;
  logic [AVS_DATA_W-1:0] r_readdata;
  logic                  r_irq;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    pio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_ch (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_raw   (pio_in[gi]),
      .o_sync  (w_sync[gi]),
      .o_stable(w_stable[gi]),
      .o_rise_c(w_rise[gi]),
      .o_fall_c(w_fall[gi])
    );
  end

  // Edge qualification is fixed at elaboration time.
  always_comb begin
    w_edge = '0;
    case (EDGE_MODE)
      EDGE_RISE: w_edge = w_rise;
      EDGE_FALL: w_edge = w_fall;
      EDGE_BOTH: w_edge = w_rise | w_fall;
      default:   w_edge = w_rise | w_fall;
    endcase
  end

  assign w_mask_we      = avs_write && (avs_address == REG_MASK);
  assign w_w1c          = (avs_write && (avs_address == REG_EDGE)) ? avs_writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^avs_writedata;

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      REG_DATA: w_rdata = AVS_DATA_W'(w_stable);
      REG_MASK: w_rdata = AVS_DATA_W'(r_mask);
      REG_EDGE: w_rdata = AVS_DATA_W'(r_edge);
      REG_RAW:  w_rdata = AVS_DATA_W'(w_sync);
      default:  w_rdata = '0;
    endcase
  end

  // New captures are OR-ed in after the clear so a same-cycle edge survives W1C.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (avs_read) begin
        r_readdata <= w_rdata;
      end
      if (w_mask_we) begin
        r_mask <= avs_writedata[WIDTH-1:0];
      end
      r_edge <= (r_edge & ~w_w1c) | w_edge;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: doc/pio_debounce_irq.md
Name: pio_debounce_irq

Overview:
Parametrised successor to the plain button/switch PIO inputs in the cpu system. It takes WIDTH asynchronous inputs, such as KEY or SW lines, and for each channel it synchronises, debounces and edge-detects the signal. Captured edges can raise a maskable interrupt. It sits as an Avalon-MM slave on the lightweight HPS/Nios bus, beside the touch UART and hex PIOs.

Parameters:
- WIDTH, 4: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 500000: consecutive stable clk_clk cycles before a level is accepted, ≥2 (10 ms at 50 MHz).
- EDGE_MODE, 2: edges captured; 0 = rising, 1 = falling, 2 = both.
- IDLE_LEVEL, 1: reset level of the sync and debounced state for every channel (1 suits active-low keys).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- pio_in  in  WIDTH  raw asynchronous inputs.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- irq  out  1  level interrupt, active high.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - Sync flops and stable state = {WIDTH{IDLE_LEVEL}}.
  - Debounce counters, mask and edge_capture = 0.
  - avs_readdata = 0, irq = 0.
- Per-channel synchroniser: 2-flop synchroniser giving sync[i].
- Per-channel debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - If sync[i] == stable[i], the counter clears to 0.
  - Otherwise it increments. When it equals DEBOUNCE_CYCLES-1, stable[i] <= sync[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency from a clean input step to the stable change = 2 + DEBOUNCE_CYCLES cycles.
- Edge detect: register stable_d. An edge is rise = stable & ~stable_d, fall = ~stable & stable_d, qualified by EDGE_MODE. An edge sets edge_capture[i] (sticky).
- Register map (readdata bits above WIDTH read 0):
  - 0 DATA (RO): stable.
  - 1 MASK (RW): irq mask [WIDTH-1:0].
  - 2 EDGE (R/W1C): writing 1 clears that bit.
  - 3 RAW (RO): sync.
- Writes to RO registers are ignored.
- Read: avs_readdata is registered 1 cycle after avs_read and holds its value until the next read.
- Simultaneous W1C and new edge on the same bit in the same cycle: the capture wins and the bit stays 1.
- irq is registered: irq <= |(edge_capture & mask). It asserts 1 cycle after the capture or mask write, and deasserts 1 cycle after clear/unmask.
- Reset mid-debounce: the counter is discarded and stable returns to IDLE_LEVEL. No edge is produced by reset release, because stable_d is also reset to IDLE_LEVEL.
- Read and write in the same cycle: the write takes effect and the read returns the pre-write value.

Decomposition:
- Package pio_pkg holds:
  - register address localparams REG_DATA=0, REG_MASK=1, REG_EDGE=2, REG_RAW=3;
  - EDGE_MODE encodings EDGE_RISE, EDGE_FALL, EDGE_BOTH.
- Sub-module pio_debounce_ch contains one channel's synchroniser, counter and stable/stable_d flops. Parameters: DEBOUNCE_CYCLES, IDLE_LEVEL. Outputs: sync, stable, rise, fall.
- The top instantiates WIDTH copies via generate and adds the register file plus irq logic.

Test Plan:
Bench parameters are WIDTH=4, DEBOUNCE_CYCLES=8, EDGE_MODE=2, IDLE_LEVEL=1.
1. Reset: hold reset_reset_n=0 with pio_in=4'hF, then release -> DATA reads 4'hF, EDGE 0, irq 0, no edge for 20 cycles.
2. Glitch rejection: pulse pio_in[0]=0 for 5 cycles -> RAW shows 4'hE during the pulse, DATA stays 4'hF, EDGE stays 0.
3. Clean press: pio_in[0]=0 held -> DATA becomes 4'hE exactly 10 cycles after the step, EDGE=4'h1. With MASK=4'h1, irq=1 one cycle later.
4. W1C: write EDGE=4'h1 -> irq drops the next cycle. Then clear bit 0 on the same cycle a new release edge arrives -> EDGE stays 4'h1 and irq stays 1.
5. Masking: MASK=0 with pending edges -> irq 0. Write MASK=4'hF -> irq 1 after 1 cycle.
6. Mid-debounce reset: assert reset after 4 cycles of low input -> DATA=4'hF after release, counter restarts, and the input must be low for a full 10 cycles again before DATA changes.
